// File: rtl/pool_out_fifo_if.sv
// Handshake bundle between the max-pool output FIFO and its producer/consumer.
// The slave side is the FIFO; the master side drives samples in and drains the head.
interface pool_out_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  row_last;
    logic                  frame_last;
    logic                  full;

    modport master (
        output valid_in, data, ready_in,
        input  data_out, valid_out, row_last, frame_last, full
    );

    modport slave (
        input  valid_in, data, ready_in,
        output data_out, valid_out, row_last, frame_last, full
    );
endinterface

// File: rtl/pool_out_fifo.sv
// FWFT output FIFO for pooled samples, tagging each with row-end/frame-end position.
// Define POOL_FIFO_OVF_EN to add the sticky `overflow` drop flag output.
module pool_out_fifo #(
    parameter int WIDTH      = 4,
    parameter int HEIGHT     = 4,
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst,
    pool_out_fifo_if.slave  bus
`ifdef POOL_FIFO_OVF_EN
    ,
    output logic            overflow
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WIDTH  > 2) ? $clog2(WIDTH / 2)  : 1;
    localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT / 2) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] COL_END  = CW'(WIDTH / 2 - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(HEIGHT / 2 - 1);

    // Entry layout: {frame_last, row_last, data}
    logic [DATA_WIDTH+1:0] mem_q [DEPTH];
    logic [DATA_WIDTH+1:0] head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    logic empty, is_full, wr, rd, tag_rl, tag_fl;

    assign empty   = (cnt_q == '0);
    assign is_full = (cnt_q == CNT_FULL);
    assign rd      = !empty && bus.ready_in;
    assign wr      = bus.valid_in && (!is_full || rd);
    assign tag_rl  = (col_q == COL_END);
    assign tag_fl  = tag_rl && (row_q == ROW_END);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        col_d    = col_q;
        row_d    = row_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            // Tracker only moves on accepted samples, so a drop's position is reused.
            if (tag_rl) begin
                col_d = '0;
                row_d = tag_fl ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
        if (rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr, rd})
            2'b10:   cnt_d = cnt_q + (AW + 1)'(1);
            2'b01:   cnt_d = cnt_q - (AW + 1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    // Storage is never cleared; stale entries are hidden by the empty mask below.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {tag_fl, tag_rl, bus.data};
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.valid_out  = !empty;
    assign bus.data_out   = empty ? '0 : head[DATA_WIDTH-1:0];
    assign bus.row_last   = !empty && head[DATA_WIDTH];
    assign bus.frame_last = !empty && head[DATA_WIDTH+1];
    assign bus.full       = is_full;

`ifdef POOL_FIFO_OVF_EN
    logic ovf_q;
    logic drop;

    assign drop = bus.valid_in && is_full && !rd;

    always_ff @(posedge clk) begin
        if (rst)       ovf_q <= 1'b0;
        else if (drop) ovf_q <= 1'b1;
    end

    assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_pool_out_fifo.sv
// Directed vector bench for pool_out_fifo: table-driven vectors plus a
// backpressure sequence checked against a queue model.
module tb_pool_out_fifo;
    localparam int WIDTH  = 4;
    localparam int HEIGHT = 4;
    localparam int DEPTH  = 8;
    localparam int DW     = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pool_out_fifo_if #(.DATA_WIDTH(DW)) bus ();

`ifdef POOL_FIFO_OVF_EN
    logic overflow;
`endif

    pool_out_fifo #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DEPTH(DEPTH), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef POOL_FIFO_OVF_EN
        , .overflow(overflow)
`endif
    );

    typedef struct {
        logic        rst;
        logic        vi;
        logic [31:0] d;
        logic        r;
        logic        ev;
        logic [31:0] ed;
        logic        erl;
        logic        efl;
        logic        efull;
        logic        eovf;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    // Backpressure model state
    logic [33:0] mq[$];
    int mcol = 0;
    int mrow = 0;

    function automatic void v(input logic rst_, input logic vi, input logic [31:0] d,
                              input logic r, input logic ev, input logic [31:0] ed,
                              input logic erl, input logic efl, input logic efull,
                              input logic eovf);
        vec_t e;
        e.rst = rst_; e.vi = vi; e.d = d; e.r = r;
        e.ev = ev; e.ed = ed; e.erl = erl; e.efl = efl; e.efull = efull; e.eovf = eovf;
        vq.push_back(e);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic vi, input logic [31:0] d, input logic r);
        logic rdm, wrm, rl, fl;
        logic [33:0] e;
        // Head must match the model whenever non-empty; this also covers hold under stall.
        if (mq.size() > 0) begin
            chk("bp_head_data", bus.data_out, {2'b0, mq[0][31:0]} );
            chk("bp_head_tags", {30'b0, bus.frame_last, bus.row_last}, {30'b0, mq[0][33:32]});
        end
        rdm = (mq.size() > 0) && r;
        wrm = vi && ((mq.size() < DEPTH) || rdm);
        if (rdm) e = mq.pop_front();
        if (wrm) begin
            rl = (mcol == WIDTH / 2 - 1);
            fl = rl && (mrow == HEIGHT / 2 - 1);
            mq.push_back({fl, rl, d});
            if (rl) begin
                mcol = 0;
                mrow = fl ? 0 : mrow + 1;
            end else begin
                mcol = mcol + 1;
            end
        end
        bus.valid_in = vi;
        bus.data     = d;
        bus.ready_in = r;
        @(posedge clk);
        #1;
        chk("bp_valid", {31'b0, bus.valid_out}, {31'b0, mq.size() > 0});
        chk("bp_full", {31'b0, bus.full}, {31'b0, mq.size() == DEPTH});
    endtask

    initial begin
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.data     = '0;
        bus.ready_in = 1'b0;

        // Reset state
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Tags, ready held high
        v(0, 1, 32'h3F800000, 1, 1, 32'h3F800000, 0, 0, 0, 0);
        v(0, 1, 32'h40000000, 1, 1, 32'h40000000, 1, 0, 0, 0);
        v(0, 1, 32'h40400000, 1, 1, 32'h40400000, 0, 0, 0, 0);
        v(0, 1, 32'h40800000, 1, 1, 32'h40800000, 1, 1, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Fill with 1..8 under stall, 9th dropped
        for (int k = 1; k <= 7; k++) v(0, 1, 32'(k), 0, 1, 1, 0, 0, 0, 0);
        v(0, 1, 8, 0, 1, 1, 0, 0, 1, 0);
        v(0, 1, 9, 0, 1, 1, 0, 0, 1, 1);
        // Drain: heads 2..8 then empty; 9 never appears
        for (int k = 2; k <= 8; k++)
            v(0, 0, 0, 1, 1, 32'(k), (k % 2 == 0), (k % 4 == 0), 0, 1);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        // Reset clears overflow
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill 0x11..0x18
        for (int k = 1; k <= 8; k++) v(0, 1, 32'(16 + k), 0, 1, 32'h11, 0, 0, (k == 8), 0);
        // Simultaneous read/write at full: no drop, order preserved
        for (int j = 2; j <= 5; j++)
            v(0, 1, 32'(16 + 7 + j), 1, 1, 32'(16 + j), (j % 2 == 0), (j % 4 == 0), 1, 0);
        for (int j = 6; j <= 12; j++)
            v(0, 0, 0, 1, 1, 32'(16 + j), (j % 2 == 0), (j % 4 == 0), 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Empty reads are ignored
        for (int k = 0; k < 5; k++) v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 32'h55, 0, 1, 32'h55, 0, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Reset mid-frame: tracker sits at col 1 after the 0x55 write
        v(0, 1, 32'hA1, 0, 1, 32'hA1, 1, 0, 0, 0);
        v(0, 1, 32'hA2, 0, 1, 32'hA1, 1, 0, 0, 0);
        v(0, 1, 32'hA3, 0, 1, 32'hA1, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v(0, 1, 32'h41000000, 0, 1, 32'h41000000, 0, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            rst          = vq[i].rst;
            bus.valid_in = vq[i].vi;
            bus.data     = vq[i].d;
            bus.ready_in = vq[i].r;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'b0, bus.valid_out}, {31'b0, vq[i].ev});
            chk($sformatf("v%0d_data", i), bus.data_out, vq[i].ed);
            chk($sformatf("v%0d_row_last", i), {31'b0, bus.row_last}, {31'b0, vq[i].erl});
            chk($sformatf("v%0d_frame_last", i), {31'b0, bus.frame_last}, {31'b0, vq[i].efl});
            chk($sformatf("v%0d_full", i), {31'b0, bus.full}, {31'b0, vq[i].efull});
`ifdef POOL_FIFO_OVF_EN
            chk($sformatf("v%0d_overflow", i), {31'b0, overflow}, {31'b0, vq[i].eovf});
`endif
        end

        // Backpressure: write every cycle with ready alternating, then drain
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mcol = 0;
        mrow = 0;
        for (int c = 0; c < 24; c++) step(1'b1, 32'h100 + 32'(c), c[0]);
        for (int c = 0; c < 10; c++) step(1'b0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
